// File: rtl/wbcon_cmd_parser.sv
// Byte-stream command parser: cmd/count/address header into a memory request, write bodies streamed downstream.
// Optional header checksum byte is enabled with `define WBCON_CMD_PARSER_CKSUM_EN.
module wbcon_cmd_parser #(
    parameter int         ADDR_WIDTH  = 24,
    parameter int         COUNT_WIDTH = 16,
    parameter int         WORD_BYTES  = 4,
    parameter int         CHAN_BITS   = 2,
    parameter logic [3:0] SYNC_NIBBLE = 4'hA
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    output logic                   o_rx_ready,
    output logic [7:0]             o_body_data,
    output logic                   o_body_valid,
    input  logic                   i_body_ready,
    output logic                   o_mreq_valid,
    input  logic                   i_mreq_ready,
    output logic [ADDR_WIDTH-1:0]  o_mreq_addr,
    output logic [COUNT_WIDTH-1:0] o_mreq_cnt,
    output logic                   o_mreq_wr,
    output logic                   o_mreq_aincr,
    output logic [CHAN_BITS-1:0]   o_mreq_chan,
    output logic [7:0]             o_err_cnt
);

    localparam int         CNT_BYTES  = (COUNT_WIDTH + 7) / 8;
    localparam int         ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int         CW8        = CNT_BYTES * 8;
    localparam int         AW8        = ADDR_BYTES * 8;
    localparam int         WB_LOG     = $clog2(WORD_BYTES);
    localparam int         REM_W      = COUNT_WIDTH + WB_LOG + 1;
    localparam logic [7:0] CNT_LAST   = 8'(CNT_BYTES - 1);
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BYTES - 1);

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_CNT   = 3'd1,
        ST_ADDR  = 3'd2,
`ifdef WBCON_CMD_PARSER_CKSUM_EN
        ST_CKSUM = 3'd3,
`endif
        ST_REQ   = 3'd4
    } state_t;

    state_t               state_r;
    logic [7:0]           idx_r;
    logic [CW8-1:0]       cnt_sh_r;
    logic [AW8-1:0]       addr_sh_r;
    logic [REM_W-1:0]     rem_r;
    logic                 acc_r;
    logic                 mreq_valid_r;
    logic                 wr_r;
    logic                 aincr_r;
    logic [CHAN_BITS-1:0] chan_r;
    logic [7:0]           err_r;
`ifdef WBCON_CMD_PARSER_CKSUM_EN
    logic [7:0]           csum_r;

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    logic             rx_ready_s;
    logic             body_valid_s;
    logic [7:0]       body_data_s;
    logic             rx_xfer_s;
    logic             body_xfer_s;
    logic             rem_nz_s;
    logic             mreq_fire_s;
    logic             mreq_done_s;
    logic             body_done_s;
    logic [CW8+7:0]   cnt_cat_s;
    logic [AW8+7:0]   addr_cat_s;
    logic [REM_W-1:0] cnt_plus1_s;
    logic [REM_W-1:0] rem_load_s;

    // Little-endian fields: each new byte enters at the top and shifts earlier bytes down.
    assign cnt_cat_s   = {i_rx_data, cnt_sh_r};
    assign addr_cat_s  = {i_rx_data, addr_sh_r};
    assign cnt_plus1_s = {{(REM_W-COUNT_WIDTH){1'b0}}, cnt_sh_r[COUNT_WIDTH-1:0]}
                       + {{(REM_W-1){1'b0}}, 1'b1};
    assign rem_load_s  = wr_r ? (cnt_plus1_s << WB_LOG) : {REM_W{1'b0}};
    assign rem_nz_s    = (rem_r != {REM_W{1'b0}});
    assign rx_xfer_s   = i_rx_valid & rx_ready_s;
    assign body_xfer_s = body_valid_s & i_body_ready;
    assign mreq_fire_s = mreq_valid_r & i_mreq_ready;
    assign mreq_done_s = acc_r | mreq_fire_s;
    assign body_done_s = ~rem_nz_s
                       | ((rem_r == {{(REM_W-1){1'b0}}, 1'b1}) & body_xfer_s);

    // Input handshake and body pass-through; body path is live only while bytes remain in REQ.
    always_comb begin
        rx_ready_s   = 1'b0;
        body_valid_s = 1'b0;
        body_data_s  = 8'h00;
        if (i_rst) begin
            rx_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_SYNC, ST_CNT, ST_ADDR: rx_ready_s = 1'b1;
`ifdef WBCON_CMD_PARSER_CKSUM_EN
                ST_CKSUM: rx_ready_s = 1'b1;
`endif
                ST_REQ: begin
                    if (rem_nz_s) begin
                        rx_ready_s   = i_body_ready;
                        body_valid_s = i_rx_valid;
                        body_data_s  = i_rx_data;
                    end else begin
                        rx_ready_s = 1'b0;
                    end
                end
                default: rx_ready_s = 1'b0;
            endcase
        end
    end

    // Header parser FSM with registered request fields and saturating garbage counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_SYNC;
            idx_r        <= 8'h00;
            cnt_sh_r     <= {CW8{1'b0}};
            addr_sh_r    <= {AW8{1'b0}};
            rem_r        <= {REM_W{1'b0}};
            acc_r        <= 1'b0;
            mreq_valid_r <= 1'b0;
            wr_r         <= 1'b0;
            aincr_r      <= 1'b0;
            chan_r       <= {CHAN_BITS{1'b0}};
            err_r        <= 8'h00;
`ifdef WBCON_CMD_PARSER_CKSUM_EN
            csum_r       <= 8'h00;
`endif
        end else begin
            if (mreq_fire_s) begin
                mreq_valid_r <= 1'b0;
                acc_r        <= 1'b1;
            end
            case (state_r)
                ST_SYNC: begin
                    if (rx_xfer_s) begin
                        if (i_rx_data[7:4] == SYNC_NIBBLE) begin
                            wr_r    <= i_rx_data[0];
                            aincr_r <= i_rx_data[1];
                            chan_r  <= i_rx_data[2 +: CHAN_BITS];
                            idx_r   <= 8'h00;
`ifdef WBCON_CMD_PARSER_CKSUM_EN
                            csum_r  <= i_rx_data;
`endif
                            state_r <= ST_CNT;
                        end else if (err_r != 8'hFF) begin
                            err_r <= err_r + 8'h01;
                        end
                    end
                end
                ST_CNT: begin
                    if (rx_xfer_s) begin
                        cnt_sh_r <= cnt_cat_s[CW8+7:8];
`ifdef WBCON_CMD_PARSER_CKSUM_EN
                        csum_r   <= csum_fold(csum_r, i_rx_data);
`endif
                        if (idx_r == CNT_LAST) begin
                            idx_r   <= 8'h00;
                            state_r <= ST_ADDR;
                        end else begin
                            idx_r <= idx_r + 8'h01;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_xfer_s) begin
                        addr_sh_r <= addr_cat_s[AW8+7:8];
`ifdef WBCON_CMD_PARSER_CKSUM_EN
                        csum_r    <= csum_fold(csum_r, i_rx_data);
`endif
                        if (idx_r == ADDR_LAST) begin
                            idx_r <= 8'h00;
`ifdef WBCON_CMD_PARSER_CKSUM_EN
                            state_r <= ST_CKSUM;
`else
                            state_r      <= ST_REQ;
                            mreq_valid_r <= 1'b1;
                            acc_r        <= 1'b0;
                            rem_r        <= rem_load_s;
`endif
                        end else begin
                            idx_r <= idx_r + 8'h01;
                        end
                    end
                end
`ifdef WBCON_CMD_PARSER_CKSUM_EN
                ST_CKSUM: begin
                    if (rx_xfer_s) begin
                        if (csum_fold(csum_r, i_rx_data) == 8'h00) begin
                            state_r      <= ST_REQ;
                            mreq_valid_r <= 1'b1;
                            acc_r        <= 1'b0;
                            rem_r        <= rem_load_s;
                        end else begin
                            state_r <= ST_SYNC;
                            if (err_r != 8'hFF) begin
                                err_r <= err_r + 8'h01;
                            end
                        end
                    end
                end
`endif
                ST_REQ: begin
                    if (body_xfer_s) begin
                        rem_r <= rem_r - {{(REM_W-1){1'b0}}, 1'b1};
                    end
                    if (mreq_done_s && body_done_s) begin
                        state_r <= ST_SYNC;
                        acc_r   <= 1'b0;
                    end
                end
                default: state_r <= ST_SYNC;
            endcase
        end
    end

    assign o_rx_ready   = rx_ready_s;
    assign o_body_data  = body_data_s;
    assign o_body_valid = body_valid_s;
    assign o_mreq_valid = mreq_valid_r;
    assign o_mreq_addr  = addr_sh_r[ADDR_WIDTH-1:0];
    assign o_mreq_cnt   = cnt_sh_r[COUNT_WIDTH-1:0];
    assign o_mreq_wr    = wr_r;
    assign o_mreq_aincr = aincr_r;
    assign o_mreq_chan  = chan_r;
    assign o_err_cnt    = err_r;

endmodule
